note_spi_master: RTL and testbench

//  SPI transmitter for the 8-bit note-status word consumed by the VGA staff display
//  (spi_slave_receive_only: q <= {q[6:0], sdi} on posedge sck).

---
 rtl/note_spi_master.sv | 164 ++++++++++++++++
 tb/tb_note_spi_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_spi_master.sv
// Mode-0 SPI transmitter for the note-status word: MSB first, sck generated from clk,
// active-low frame strobe, fixed idle gap between frames.
module note_spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             sck,
  output logic             sdi,
  output logic             cs_b
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(WIDTH) + 1;
  localparam int GAP_W = $clog2(GAP) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               sck_q, sck_d;
  logic               sdi_q, sdi_d;
  logic               cs_b_q, cs_b_d;
  logic               done_q, done_d;
  logic               tx_ready_q, tx_ready_d;
  logic               busy_q, busy_d;
  logic               accept_s;

  assign accept_s = tx_valid & tx_ready_q;

  // Next-state and next-output logic for the IDLE -> SHIFT -> GAP sequence.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    sck_d   = sck_q;
    sdi_d   = sdi_q;
    cs_b_d  = cs_b_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SHIFT;
          shreg_d = tx_data;
          sdi_d   = tx_data[WIDTH-1];
          cs_b_d  = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling sck: either advance to the next bit or close the frame.
            sck_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_GAP;
              sdi_d   = 1'b0;
              cs_b_d  = 1'b1;
              done_d  = 1'b1;
              bit_d   = '0;
              gap_d   = '0;
              shreg_d = '0;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
              sdi_d   = shreg_q[WIDTH-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        bit_d   = '0;
        gap_d   = '0;
        shreg_d = '0;
        sck_d   = 1'b0;
        sdi_d   = 1'b0;
        cs_b_d  = 1'b1;
      end
    endcase

    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d == ST_SHIFT) || (state_d == ST_GAP);
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      shreg_q    <= '0;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
      cs_b_q     <= 1'b1;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      shreg_q    <= shreg_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      cs_b_q     <= cs_b_d;
      done_q     <= done_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sck      = sck_q;
  assign sdi      = sdi_q;
  assign cs_b     = cs_b_q;

endmodule

// File: tb/tb_note_spi_master.sv
// Directed bench for note_spi_master: a shift-only slave model per instance checks each
// frame against a scoreboard of accepted words (CLK_DIV=4 and CLK_DIV=1 instances).
module tb_note_spi_master;

  localparam int WIDTH = 8;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic reset_b = 1'b0;

  logic [7:0] tx_data_a = 8'h00, tx_data_b = 8'h00;
  logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic       tx_ready_a, busy_a, done_a, sck_a, sdi_a, cs_b_a;
  logic       tx_ready_b, busy_b, done_b, sck_b, sdi_b, cs_b_b;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int         divs[2] = '{4, 1};
  int         cyc = 0;
  int         acc_cnt[2]  = '{0, 0};
  int         acc_last[2] = '{0, 0};
  int         acc_prev[2] = '{0, 0};
  logic       rst_at_edge = 1'b1;

  logic [7:0] q[2]       = '{8'h00, 8'h00};
  int         rises[2]   = '{0, 0};
  int         low[2]     = '{0, 0};
  int         hi[2]      = '{0, 0};
  int         sdi_hi[2]  = '{0, 0};
  int         dones[2]   = '{0, 0};
  int         frames[2]  = '{0, 0};
  int         since[2]   = '{0, 0};
  logic       track[2]   = '{1'b0, 1'b0};
  logic       sck_p[2]   = '{1'b0, 1'b0};
  logic       cs_p[2]    = '{1'b1, 1'b1};

  note_spi_master #(.WIDTH(WIDTH), .CLK_DIV(4), .GAP(GAP)) dut_a (
    .clk(clk), .reset_b(reset_b), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .busy(busy_a), .done(done_a), .sck(sck_a), .sdi(sdi_a), .cs_b(cs_b_a)
  );

  note_spi_master #(.WIDTH(WIDTH), .CLK_DIV(1), .GAP(GAP)) dut_b (
    .clk(clk), .reset_b(reset_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .busy(busy_b), .done(done_b), .sck(sck_b), .sdi(sdi_b), .cs_b(cs_b_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept detection feeds the scoreboard with the word the DUT latched.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= !reset_b;
    if (reset_b && tx_valid_a && tx_ready_a) begin
      exp_q0.push_back(tx_data_a);
      acc_cnt[0]  <= acc_cnt[0] + 1;
      acc_prev[0] <= acc_last[0];
      acc_last[0] <= cyc;
    end
    if (reset_b && tx_valid_b && tx_ready_b) begin
      exp_q1.push_back(tx_data_b);
      acc_cnt[1]  <= acc_cnt[1] + 1;
      acc_prev[1] <= acc_last[1];
      acc_last[1] <= cyc;
    end
  end

  task automatic mon_step(input int k, input logic s_sck, input logic s_sdi, input logic s_cs,
                          input logic s_done, input logic s_ready, input logic s_busy);
    logic [7:0] exp;
    logic       have;
    if (rst_at_edge) begin
      q[k] = 8'h00; rises[k] = 0; low[k] = 0; hi[k] = 0; sdi_hi[k] = 0; dones[k] = 0;
      sck_p[k] = 1'b0; cs_p[k] = 1'b1; track[k] = 1'b0;
      return;
    end
    if (!s_cs && cs_p[k]) begin
      q[k] = 8'h00; rises[k] = 0; low[k] = 0; hi[k] = 0; sdi_hi[k] = 0; dones[k] = 0;
    end
    if (!s_cs) begin
      low[k]++;
      if (s_sck) hi[k]++;
      if (s_sdi) sdi_hi[k]++;
      if (s_sck && !sck_p[k]) begin
        rises[k]++;
        q[k] = {q[k][6:0], s_sdi};
      end
    end
    if (s_done) dones[k]++;
    if (s_cs && !cs_p[k]) begin
      frames[k]++;
      have = (k == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      check($sformatf("sb_has_entry%0d", k), 32'(have), 32'd1);
      if (have) begin
        if (k == 0) exp = exp_q0.pop_front();
        else        exp = exp_q1.pop_front();
        check($sformatf("slave_q%0d", k), 32'(q[k]), 32'(exp));
        check($sformatf("sdi_high_cycles%0d", k), 32'(sdi_hi[k]), 32'($countones(exp) * 2 * divs[k]));
      end
      check($sformatf("sck_rises%0d", k), 32'(rises[k]), 32'(WIDTH));
      check($sformatf("cs_low_cycles%0d", k), 32'(low[k]), 32'(WIDTH * 2 * divs[k]));
      check($sformatf("sck_high_cycles%0d", k), 32'(hi[k]), 32'(WIDTH * divs[k]));
      check($sformatf("done_pulses%0d", k), 32'(dones[k]), 32'd1);
      check($sformatf("done_at_cs_rise%0d", k), 32'(s_done), 32'd1);
      check($sformatf("gap_idle_lines%0d", k), 32'({s_sck, s_sdi}), 32'd0);
      check($sformatf("ready_busy_excl%0d", k), 32'(s_ready & s_busy), 32'd0);
      track[k] = 1'b1;
      since[k] = 0;
    end else if (track[k]) begin
      since[k]++;
      if (s_ready) begin
        check($sformatf("cs_rise_to_ready%0d", k), 32'(since[k]), 32'(GAP));
        track[k] = 1'b0;
      end
    end
    sck_p[k] = s_sck;
    cs_p[k]  = s_cs;
  endtask

  // Slave model and frame monitor, sampled away from the active edge.
  always @(negedge clk) begin
    mon_step(0, sck_a, sdi_a, cs_b_a, done_a, tx_ready_a, busy_a);
    mon_step(1, sck_b, sdi_b, cs_b_b, done_b, tx_ready_b, busy_b);
  end

  task automatic wait_accept(input int k, input int start, input int budget);
    int n = 0;
    while (acc_cnt[k] <= start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_in_time%0d", k), 32'(acc_cnt[k] > start), 32'd1);
  endtask

  task automatic wait_frames(input int k, input int target, input int budget);
    int n = 0;
    while (frames[k] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("frame_in_time%0d", k), 32'(frames[k] >= target), 32'd1);
  endtask

  task automatic send_a(input logic [7:0] d);
    int start;
    start = acc_cnt[0];
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    wait_accept(0, start, 200);
    tx_valid_a = 1'b0;
  endtask

  initial begin
    int start;
    int fr;

    // Reset state
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck",   32'(sck_a),      32'd0);
    check("rst_sdi",   32'(sdi_a),      32'd0);
    check("rst_cs_b",  32'(cs_b_a),     32'd1);
    check("rst_ready", 32'(tx_ready_a), 32'd1);
    check("rst_busy",  32'(busy_a),     32'd0);
    check("rst_done",  32'(done_a),     32'd0);
    check("rst_ready_b", 32'(tx_ready_b), 32'd1);
    check("rst_cs_b_b",  32'(cs_b_b),     32'd1);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 8'hA5
    send_a(8'hA5);
    check("busy_in_shift", 32'(busy_a), 32'd1);
    check("ready_in_shift", 32'(tx_ready_a), 32'd0);
    check("first_bit", 32'(sdi_a), 32'd1);
    wait_frames(0, 1, 200);
    repeat (10) @(negedge clk);

    // Back-to-back with tx_valid held; data changes after the first accept
    start = acc_cnt[0];
    tx_data_a  = 8'h0F;
    tx_valid_a = 1'b1;
    wait_accept(0, start, 200);
    tx_data_a = 8'hF0;
    wait_accept(0, start + 1, 200);
    tx_valid_a = 1'b0;
    check("b2b_accept_spacing", 32'(acc_last[0] - acc_prev[0]), 32'(1 + WIDTH * 2 * 4 + GAP));
    wait_frames(0, 3, 400);
    repeat (10) @(negedge clk);

    // tx_valid pulse during a frame is ignored
    send_a(8'hC3);
    repeat (20) @(negedge clk);
    fr = acc_cnt[0];
    tx_data_a  = 8'h33;
    tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    check("midframe_no_accept", 32'(acc_cnt[0]), 32'(fr));
    wait_frames(0, 4, 200);
    repeat (10) @(negedge clk);
    check("midframe_frames", 32'(frames[0]), 32'd4);
    check("midframe_sb_empty", 32'(exp_q0.size()), 32'd0);

    // Reset during bit 3 of 8'hFF aborts the frame
    send_a(8'hFF);
    repeat (28) @(negedge clk);
    check("pre_abort_cs_low", 32'(cs_b_a), 32'd0);
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    check("abort_sck",   32'(sck_a),      32'd0);
    check("abort_cs_b",  32'(cs_b_a),     32'd1);
    check("abort_ready", 32'(tx_ready_a), 32'd1);
    check("abort_busy",  32'(busy_a),     32'd0);
    check("abort_done",  32'(done_a),     32'd0);
    exp_q0.delete();
    @(negedge clk);
    send_a(8'h01);
    wait_frames(0, 5, 200);
    repeat (10) @(negedge clk);
    check("frames_after_abort", 32'(frames[0]), 32'd5);

    // CLK_DIV=1 instance, 8'h80
    start = acc_cnt[1];
    tx_data_b  = 8'h80;
    tx_valid_b = 1'b1;
    wait_accept(1, start, 50);
    tx_valid_b = 1'b0;
    check("div1_first_sck_low", 32'(sck_b), 32'd0);
    @(negedge clk);
    check("div1_sck_toggles", 32'(sck_b), 32'd1);
    wait_frames(1, 1, 100);
    repeat (10) @(negedge clk);
    check("sb_a_drained", 32'(exp_q0.size()), 32'd0);
    check("sb_b_drained", 32'(exp_q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
